// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and helpers for the vector writeback collector
package vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WB      = 2'd2
    } state_t;

    localparam logic [2:0] VSEW_E8  = 3'd0;
    localparam logic [2:0] VSEW_E16 = 3'd1;
    localparam logic [2:0] VSEW_E32 = 3'd2;
    localparam logic [2:0] VSEW_E64 = 3'd3;

    // Chunk width a lane writes per beat: element width capped by the lane datapath.
    function automatic logic [6:0] chunk_width(input logic [2:0] vsew, input int unsigned lane_width);
        int unsigned sew;
        int unsigned cap;
        sew = 32'd8 << vsew;
        cap = 32'd1 << lane_width;
        return (sew < cap) ? sew[6:0] : cap[6:0];
    endfunction

endpackage

// File: rtl/vec_lane_merge.sv
// rtl/vec_lane_merge.sv - places one lane chunk into a VLEN-wide image with bit/byte masks
module vec_lane_merge #(
    parameter int VLEN = 128
) (
    input  logic [63:0]       i_data,
    input  logic [9:0]        i_idx,
    input  logic              i_vld,
    input  logic [6:0]        i_w,
    output logic [VLEN-1:0]   o_bit_mask,
    output logic [VLEN/8-1:0] o_byte_mask,
    output logic [VLEN-1:0]   o_shifted,
    output logic              o_oob
);

    logic        w_fits;
    logic [63:0] w_chunk_mask;

    assign w_fits       = ((32'(i_idx) + 32'(i_w)) <= VLEN);
    assign w_chunk_mask = (i_w >= 7'd64) ? '1 : ((64'd1 << i_w) - 64'd1);
    assign o_shifted    = {{(VLEN-64){1'b0}}, i_data & w_chunk_mask} << i_idx;
    assign o_bit_mask   = (i_vld && w_fits) ? ({{(VLEN-64){1'b0}}, w_chunk_mask} << i_idx) : '0;
    assign o_oob        = i_vld && !w_fits;

    // A byte counts as written when any of its bits is covered.
    for (genvar b = 0; b < VLEN/8; b++) begin : g_byte
        assign o_byte_mask[b] = |o_bit_mask[8*b +: 8];
    end

endmodule

// File: rtl/vec_wb_collector.sv
// rtl/vec_wb_collector.sv - gathers lane chunks into a vector and writes it back via valid/ready
module vec_wb_collector
    import vec_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4,
    parameter int NB_LANES   = 2
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_start,
    input  logic [4:0]        i_vd_addr,
    input  logic [2:0]        i_vsew,
    input  logic              i_flush,
    input  logic [63:0]       i_lane_vd0,
    input  logic [63:0]       i_lane_vd1,
    input  logic [63:0]       i_lane_vd2,
    input  logic [63:0]       i_lane_vd3,
    input  logic [9:0]        i_lane_idx0,
    input  logic [9:0]        i_lane_idx1,
    input  logic [9:0]        i_lane_idx2,
    input  logic [9:0]        i_lane_idx3,
    input  logic              i_lane_vld0,
    input  logic              i_lane_vld1,
    input  logic              i_lane_vld2,
    input  logic              i_lane_vld3,
    input  logic              i_alu_done,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [4:0]        o_wb_addr,
    output logic [VLEN-1:0]   o_wb_data,
    output logic [VLEN/8-1:0] o_wb_be,
    output logic              o_busy,
    output logic              o_err_oob
);

    localparam int NLANES = 1 << NB_LANES;

    state_t            r_state;
    state_t            w_state_next;
    logic [VLEN-1:0]   r_acc;
    logic [VLEN/8-1:0] r_mask;
    logic [4:0]        r_addr;
    logic [2:0]        r_vsew;
    logic              r_err;

    logic [63:0]       w_vd       [4];
    logic [9:0]        w_idx      [4];
    logic [3:0]        w_vld_raw;
    logic [3:0]        w_vld;
    logic [6:0]        w_w;
    logic [VLEN-1:0]   w_bit_mask [4];
    logic [VLEN/8-1:0] w_byte_mask[4];
    logic [VLEN-1:0]   w_shifted  [4];
    logic [3:0]        w_oob;
    logic [VLEN-1:0]   w_acc_next;
    logic [VLEN/8-1:0] w_mask_next;

    assign w_vd      = '{i_lane_vd0, i_lane_vd1, i_lane_vd2, i_lane_vd3};
    assign w_idx     = '{i_lane_idx0, i_lane_idx1, i_lane_idx2, i_lane_idx3};
    assign w_vld_raw = {i_lane_vld3, i_lane_vld2, i_lane_vld1, i_lane_vld0};
    assign w_w       = chunk_width(r_vsew, LANE_WIDTH);

    // Lanes beyond the configured count never write; beats only land while collecting.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        if (k < NLANES) begin : g_on
            assign w_vld[k] = w_vld_raw[k] && (r_state == ST_COLLECT);
        end else begin : g_off
            assign w_vld[k] = 1'b0;
        end
        vec_lane_merge #(.VLEN(VLEN)) u_merge (
            .i_data     (w_vd[k]),
            .i_idx      (w_idx[k]),
            .i_vld      (w_vld[k]),
            .i_w        (w_w),
            .o_bit_mask (w_bit_mask[k]),
            .o_byte_mask(w_byte_mask[k]),
            .o_shifted  (w_shifted[k]),
            .o_oob      (w_oob[k])
        );
    end

    // Applied in ascending lane order so the highest lane wins on overlap.
    always_comb begin
        w_acc_next  = r_acc;
        w_mask_next = r_mask;
        for (int k = 0; k < 4; k++) begin
            w_acc_next  = (w_acc_next & ~w_bit_mask[k]) | (w_shifted[k] & w_bit_mask[k]);
            w_mask_next = w_mask_next | w_byte_mask[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (i_start)    w_state_next = ST_COLLECT;
                ST_COLLECT: if (i_alu_done) w_state_next = ST_WB;
                ST_WB:      if (i_wb_ready) w_state_next = ST_IDLE;
                default:                    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_addr <= '0;
            r_vsew <= VSEW_E8;
            r_err  <= 1'b0;
        end else if (!i_flush) begin
            if (r_state == ST_IDLE && i_start) begin
                r_acc  <= '0;
                r_mask <= '0;
                r_err  <= 1'b0;
                r_addr <= i_vd_addr;
                r_vsew <= i_vsew;
            end else if (r_state == ST_COLLECT) begin
                r_acc  <= w_acc_next;
                r_mask <= w_mask_next;
                r_err  <= r_err | (|w_oob);
            end
        end
    end

    assign o_wb_valid = (r_state == ST_WB);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_wb_addr  = r_addr;
    assign o_wb_data  = r_acc;
    assign o_wb_be    = r_mask;
    assign o_err_oob  = r_err;

endmodule

// File: tb/tb_vec_wb_collector.sv
// tb/tb_vec_wb_collector.sv - directed self-checking bench for vec_wb_collector
module tb_vec_wb_collector;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [4:0]   vd_addr;
    logic [2:0]   vsew;
    logic         flush;
    logic [63:0]  vd  [4];
    logic [9:0]   idx [4];
    logic [3:0]   vld;
    logic         alu_done;
    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_addr;
    logic [127:0] wb_data;
    logic [15:0]  wb_be;
    logic         busy;
    logic         err_oob;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [127:0] snap_data;
    logic [15:0]  snap_be;

    vec_wb_collector #(.VLEN(128), .LANE_WIDTH(4), .NB_LANES(2)) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_start    (start),
        .i_vd_addr  (vd_addr),
        .i_vsew     (vsew),
        .i_flush    (flush),
        .i_lane_vd0 (vd[0]),
        .i_lane_vd1 (vd[1]),
        .i_lane_vd2 (vd[2]),
        .i_lane_vd3 (vd[3]),
        .i_lane_idx0(idx[0]),
        .i_lane_idx1(idx[1]),
        .i_lane_idx2(idx[2]),
        .i_lane_idx3(idx[3]),
        .i_lane_vld0(vld[0]),
        .i_lane_vld1(vld[1]),
        .i_lane_vld2(vld[2]),
        .i_lane_vld3(vld[3]),
        .i_alu_done (alu_done),
        .o_wb_valid (wb_valid),
        .i_wb_ready (wb_ready),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_data),
        .o_wb_be    (wb_be),
        .o_busy     (busy),
        .o_err_oob  (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < 4; k++) begin
            vd[k]  = '0;
            idx[k] = '0;
        end
        vld      = '0;
        alu_done = 1'b0;
    endtask

    task automatic lane(input int k, input logic [63:0] d, input logic [9:0] i);
        vd[k]  = d;
        idx[k] = i;
        vld[k] = 1'b1;
    endtask

    task automatic do_start(input logic [4:0] a, input logic [2:0] s);
        start   = 1'b1;
        vd_addr = a;
        vsew    = s;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        vd_addr  = '0;
        vsew     = '0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        clear_lanes();
        #2;
        chk("rst_valid", 128'(wb_valid), 128'd0);
        chk("rst_busy",  128'(busy),     128'd0);
        chk("rst_data",  wb_data,        128'd0);
        chk("rst_be",    128'(wb_be),    128'd0);
        chk("rst_addr",  128'(wb_addr),  128'd0);
        chk("rst_err",   128'(err_oob),  128'd0);
        tick();
        resetn = 1'b1;
        tick();

        // E8, four lanes, four beats
        do_start(5'd5, 3'd0);
        chk("e8_busy", 128'(busy), 128'd1);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) lane(k, 64'(4*b + k), 10'(8*(4*b + k)));
            alu_done = (b == 3);
            tick();
            if (b == 2) chk("e8_no_early_valid", 128'(wb_valid), 128'd0);
        end
        clear_lanes();
        chk("e8_valid", 128'(wb_valid), 128'd1);
        chk("e8_data",  wb_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("e8_be",    128'(wb_be),   128'h FFFF);
        chk("e8_addr",  128'(wb_addr), 128'd5);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("e8_valid_drop", 128'(wb_valid), 128'd0);
        chk("e8_busy_drop",  128'(busy),     128'd0);

        // E32 split chunks, upper bits of lane data must be discarded, then backpressure
        do_start(5'd9, 3'd2);
        lane(0, 64'h1234_0000_BEEF, 10'd0);
        tick();
        lane(0, 64'h5678_0000_DEAD, 10'd16);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        chk("e32_valid", 128'(wb_valid), 128'd1);
        chk("e32_data",  wb_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        chk("e32_be",    128'(wb_be), 128'h000F);
        snap_data = 128'hDEAD_BEEF;
        snap_be   = 16'h000F;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_valid", 128'(wb_valid), 128'd1);
            chk("bp_data",  wb_data,        snap_data);
            chk("bp_be",    128'(wb_be),    128'(snap_be));
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("bp_busy_after", 128'(busy), 128'd0);

        // Out of range chunk on lane 2, other lanes merge
        do_start(5'd3, 3'd1);
        lane(0, 64'h1111, 10'd0);
        lane(1, 64'h2222, 10'd16);
        lane(2, 64'h3333, 10'd120);
        lane(3, 64'h4444, 10'd32);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        chk("oob_err",  128'(err_oob), 128'd1);
        chk("oob_data", wb_data, 128'h0000_0000_0000_0000_0000_4444_2222_1111);
        chk("oob_be",   128'(wb_be), 128'h003F);
        chk("oob_be15", 128'(wb_be[15]), 128'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // Collision: lane 3 beats lane 0; start while busy is ignored
        do_start(5'd4, 3'd0);
        chk("col_err_cleared", 128'(err_oob), 128'd0);
        lane(0, 64'h11, 10'd0);
        lane(3, 64'h33, 10'd0);
        alu_done = 1'b1;
        start    = 1'b1;
        vd_addr  = 5'd31;
        tick();
        start = 1'b0;
        clear_lanes();
        chk("col_data", wb_data, 128'h33);
        chk("col_be",   128'(wb_be),   128'h0001);
        chk("col_addr", 128'(wb_addr), 128'd4);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // alu_done with no valid lanes
        do_start(5'd12, 3'd0);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        chk("empty_valid", 128'(wb_valid), 128'd1);
        chk("empty_be",    128'(wb_be),    128'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;

        // Asynchronous reset mid-collect
        do_start(5'd7, 3'd0);
        lane(0, 64'hAA, 10'd0);
        tick();
        clear_lanes();
        chk("pre_rst_data", wb_data, 128'hAA);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 128'(busy),    128'd0);
        chk("arst_data", wb_data,       128'd0);
        chk("arst_addr", 128'(wb_addr), 128'd0);
        chk("arst_be",   128'(wb_be),   128'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Flush in WB drops the writeback
        do_start(5'd21, 3'd0);
        lane(1, 64'h55, 10'd8);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        chk("fl_valid_before", 128'(wb_valid), 128'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 128'(wb_valid), 128'd0);
        chk("fl_busy",  128'(busy),     128'd0);

        // New start accepted after flush
        do_start(5'd17, 3'd0);
        chk("post_fl_busy", 128'(busy), 128'd1);
        alu_done = 1'b1;
        tick();
        clear_lanes();
        chk("post_fl_addr", 128'(wb_addr), 128'd17);
        chk("post_fl_be",   128'(wb_be),   128'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("post_fl_idle", 128'(busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/vec_wb_collector.md
# vec_wb_collector

Downstream stage of the vector ALU lane wrapper. It gathers the per-lane partial results (`vd0..vd3` at bit offsets `regi0..regi3`, qualified by `res0..res3`) into one VLEN-bit destination image and a byte-written mask. On `done`, it presents the assembled vector to the vector register file through a valid/ready write port. It is the only path from ALU lanes to register-file writeback.

## Interface
- `VLEN`, 128: vector register width in bits (multiple of 64).
- `LANE_WIDTH`, 4: log2 of max bits a lane produces per cycle (chunk width cap = 1<<LANE_WIDTH).
- `NB_LANES`, 2: log2 of lane count (lanes present: 1<<NB_LANES, max 4).
- `clk` in 1: clock.
- `resetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: begin a new collection (accepted only in IDLE).
- `vd_addr` in 5: destination register index, latched on accepted `start`.
- `vsew` in 3: element width code (SEW = 8<<vsew), latched on accepted `start`.
- `flush` in 1: synchronous abort to IDLE.
- `lane_vd0..3` in 64 each: lane result data, LSB-aligned.
- `lane_idx0..3` in 10 each: destination bit offset of that lane's chunk.
- `lane_vld0..3` in 1 each: lane chunk valid this cycle.
- `alu_done` in 1: last lane beat of the instruction is this cycle.
- `wb_valid` out 1: writeback request.
- `wb_ready` in 1: register file accepts.
- `wb_addr` out 5: latched `vd_addr`.
- `wb_data` out VLEN: assembled vector.
- `wb_be` out VLEN/8: byte enables (bytes written during collection).
- `busy` out 1: state != IDLE.
- `err_oob` out 1: sticky; a lane chunk fell outside VLEN.

## Operation
- States: IDLE, COLLECT, WB.
  - IDLE→COLLECT on `start`. Clears the accumulator, mask and `err_oob`; latches `vd_addr` and `vsew`.
  - COLLECT→WB on the cycle after `alu_done` is sampled high. Lane writes in the `alu_done` cycle are included.
  - WB→IDLE on `wb_valid && wb_ready`.
  - `flush` in any state → IDLE next cycle, with no writeback. `flush` has priority over every other transition.
- Chunk width `w = min(8<<vsew, 1<<LANE_WIDTH)` bits, computed from the latched `vsew`.
- Each cycle in COLLECT, for each lane k with `lane_vld_k`:
  - If `lane_idx_k + w <= VLEN`: `acc[lane_idx_k +: w] <= lane_vd_k[w-1:0]` and the covered mask bytes are set.
  - Otherwise the write is dropped and `err_oob` is set.
- Same-cycle overlapping lanes: the higher lane number wins.
- `lane_vld*` and `alu_done` are ignored outside COLLECT.
- `start` is ignored while `busy` is high.
- `alu_done` with no prior valid lanes → WB with `wb_be` = 0. This is legal.
- `wb_data`/`wb_be` drive the accumulator and mask directly. Both are frozen in WB.
- Only the lanes present per `NB_LANES` are used; absent lanes are tied inactive internally.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `wb_valid` 0, `wb_addr` 0, `wb_data` 0, `wb_be` 0, `busy` 0, `err_oob` 0.
- `start` at cycle t → `busy` high at t+1. Lane beats are accepted from t+1.
- `alu_done` at cycle n → `wb_valid` high at n+1 with final data.
- `wb_valid` is held high, and `wb_addr`/`wb_data`/`wb_be` held stable, until the cycle `wb_ready` is high. `wb_ready` is a don't-care while `wb_valid` is low.
- Handshake at cycle m → `wb_valid` and `busy` low at m+1. A new `start` is accepted at m+1 at the earliest.
- Minimum instruction occupancy: start + 1 beat + 1 WB = 3 cycles.
- Reset asserted mid-COLLECT or mid-WB: outputs go to reset values immediately. The pending writeback is lost.

## Structure
- Package `vec_pkg`: state encoding; VSEW codes (E8=0, E16=1, E32=2, E64=3); the chunk-width function.
- Sub-module `vec_lane_merge`: combinational, one instance per lane.
  - Inputs: data, idx, vld, w.
  - Outputs: a VLEN-wide bit mask, a VLEN/8 byte mask, a shifted data word, and an oob flag.
  - The top level ORs the masks in lane order (lane 3 last), then updates registers.
- Top-level FSM and registers: ~150–250 lines.

## Test plan
- **E8, four lanes:** VLEN=128; `start` with `vd_addr`=5, `vsew`=0. Four beats, each with all lanes valid, `lane_vd_k` = element index, `lane_idx_k` = 8·index; `alu_done` on beat 4. Required: `wb_data` = 0x0F0E0D0C0B0A09080706050403020100, `wb_be` = 16'hFFFF, `wb_addr` = 5, `wb_valid` 1 cycle after beat 4.
- **E32 split chunks:** `vsew`=2 (w=16). Lane 0 writes 0xBEEF at idx 0, then 0xDEAD at idx 16. Required: `wb_data[31:0]` = 0xDEADBEEF, `wb_be` = 16'h000F.
- **Backpressure:** `wb_ready` low for 3 cycles. Required: `wb_valid`, `wb_data` and `wb_be` are unchanged throughout. Handshake on cycle 4; `busy` is 0 the next cycle.
- **Out of range:** `vsew`=1, lane 2 with idx=120 (120+16 > 128). Required: write dropped, `err_oob`=1, `wb_be[15]`=0, other lanes merged normally.
- **Collision:** lanes 0 and 3 both at idx 0, data 0x11 and 0x33, `vsew`=0. Required: byte 0 = 0x33.
- **Reset and flush:** `resetn` low mid-COLLECT → all outputs 0 in the same cycle. After restart, `flush` in WB → `wb_valid` 0 next cycle, IDLE, no handshake required.
